// File: rtl/compress_pkg.sv
// Shared types and constants for the Stage1 compression datapath.
package compress_pkg;
    localparam int         DATA_WIDTH      = 32;
    localparam int         TOTAL_WORDS     = 16;
    localparam int         SIZE            = 8;
    localparam int         MIN_MATCH_BYTES = 2;
    localparam logic [3:0] BYTE_FULL       = 4'b1111;

    typedef struct packed {
        logic                  hit;
        logic [3:0]            loc;
        logic [3:0]            mask;
        logic [DATA_WIDTH-1:0] lit;
    } match_res_t;

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} pace_state_t;

    function automatic logic [2:0] popcnt4(input logic [3:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction
endpackage

// File: rtl/dict_best_match.sv
// One word's dictionary compare: byte masks against every entry (pre-S1) and
// best-candidate selection from the registered masks (S1 -> S2).
module dict_best_match
    import compress_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]             word,
    input  logic [TOTAL_WORDS*DATA_WIDTH-1:0] dict,
    input  logic [TOTAL_WORDS-1:0]            ent_vld,
    output logic [TOTAL_WORDS-1:0][3:0]       masks,
    input  logic [TOTAL_WORDS-1:0][3:0]       masks_q,
    input  logic [DATA_WIDTH-1:0]             lit_q,
    output match_res_t                        res
);
    logic [2:0] best;

    always_comb begin
        masks = '0;
        for (int j = 0; j < TOTAL_WORDS; j++)
            for (int k = 0; k < 4; k++)
                masks[j][k] = ent_vld[j] &
                              (dict[j*DATA_WIDTH + 8*k +: 8] == word[8*k +: 8]);
    end

    // Strict '>' while scanning upward keeps the lowest index on ties.
    always_comb begin
        res     = '0;
        res.lit = lit_q;
        best    = 3'(MIN_MATCH_BYTES - 1);
        for (int j = 0; j < TOTAL_WORDS; j++) begin
            if (popcnt4(masks_q[j]) > best) begin
                best     = popcnt4(masks_q[j]);
                res.hit  = 1'b1;
                res.loc  = 4'(j);
                res.mask = masks_q[j];
            end
        end
    end
endmodule

// File: rtl/dict_match_search.sv
// Match-search stage: paced pair intake, dictionary write strobes, two-stage
// compare/select pipeline producing per-word match or literal results.
module dict_match_search
    import compress_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TOTAL_WORDS = 16,
    parameter int SIZE        = 8
)(
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_valid,
    output logic                             o_in_ready,
    input  logic [DATA_WIDTH-1:0]            i_data0,
    input  logic [DATA_WIDTH-1:0]            i_data1,
    input  logic                             i_data1_vld,
    input  logic [TOTAL_WORDS*DATA_WIDTH-1:0] i_dict,
    output logic                             o_wr,
    output logic                             o_wr2,
    output logic [DATA_WIDTH-1:0]            o_w_data,
    output logic [DATA_WIDTH-1:0]            o_w_data2,
    output logic                             o_valid,
    input  logic                             i_out_ready,
    output logic                             o_vld1,
    output logic [1:0]                       o_hit,
    output logic [3:0]                       o_loc0,
    output logic [3:0]                       o_loc1,
    output logic [3:0]                       o_mask0,
    output logic [3:0]                       o_mask1,
    output logic [DATA_WIDTH-1:0]            o_lit0,
    output logic [DATA_WIDTH-1:0]            o_lit1
);
    localparam int PW        = $clog2(SIZE);
    localparam int NUM_LANES = 2;

    pace_state_t                                   state;
    logic [2:1]                                    vld_pipe;
    logic                                          adv, fire, wr_q, wr2_q, s1_vld1;
    logic [TOTAL_WORDS-1:0]                        ent_vld;
    logic [PW-1:0]                                 wp;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]          word, s1_lit;
    logic [NUM_LANES-1:0][TOTAL_WORDS-1:0][3:0]    masks, s1_masks;
    match_res_t [NUM_LANES-1:0]                    res;

    assign word       = {i_data1, i_data0};
    assign o_valid    = vld_pipe[2];
    assign adv        = i_out_ready | ~o_valid;
    assign o_in_ready = i_reset & (state == IDLE) & adv;
    assign fire       = i_valid & o_in_ready;
    // Keep the FIFO from capturing a strobe on the reset edge.
    assign o_wr       = wr_q & i_reset;
    assign o_wr2      = wr2_q & i_reset;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dict_best_match u_bm (
            .word    (word[l]),
            .dict    (i_dict),
            .ent_vld (ent_vld),
            .masks   (masks[l]),
            .masks_q (s1_masks[l]),
            .lit_q   (s1_lit[l]),
            .res     (res[l])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state     <= IDLE;
            vld_pipe  <= '0;
            wr_q      <= 1'b0;
            wr2_q     <= 1'b0;
            o_w_data  <= '0;
            o_w_data2 <= '0;
            ent_vld   <= '0;
            wp        <= '0;
            s1_vld1   <= 1'b0;
            s1_lit    <= '0;
            s1_masks  <= '0;
            o_vld1    <= 1'b0;
            o_hit     <= '0;
            o_loc0    <= '0;
            o_loc1    <= '0;
            o_mask0   <= '0;
            o_mask1   <= '0;
            o_lit0    <= '0;
            o_lit1    <= '0;
        end else begin
            unique case (state)
                IDLE:    if (fire) state <= WAIT1;
                WAIT1:   state <= WAIT2;
                default: state <= IDLE;
            endcase

            wr_q  <= fire;
            wr2_q <= fire & i_data1_vld;
            if (fire) begin
                o_w_data  <= i_data0;
                o_w_data2 <= i_data1;
            end

            // Mirror of the FIFO write pointer; overwritten entries stay valid.
            if (wr_q) begin
                ent_vld[{wp, 1'b0}] <= 1'b1;
                if (wr2_q) ent_vld[{wp, 1'b1}] <= 1'b1;
                wp <= (wp == PW'(SIZE - 1)) ? '0 : wp + 1'b1;
            end

            if (adv) begin
                vld_pipe <= {vld_pipe[1], fire};
                if (fire) begin
                    s1_lit   <= word;
                    s1_masks <= masks;
                    s1_vld1  <= i_data1_vld;
                end
                if (vld_pipe[1]) begin
                    o_vld1  <= s1_vld1;
                    o_hit   <= {res[1].hit & s1_vld1, res[0].hit};
                    o_loc0  <= res[0].loc;
                    o_loc1  <= res[1].loc;
                    o_mask0 <= res[0].mask;
                    o_mask1 <= res[1].mask;
                    o_lit0  <= res[0].lit;
                    o_lit1  <= res[1].lit;
                end
            end
        end
    end
endmodule

// File: tb/tb_dict_match_search.sv
// Directed + random bench for dict_match_search with a dictionary FIFO model
// and a behavioural best-match reference.
module tb_dict_match_search;
    logic         i_clk = 1'b0;
    logic         i_reset, i_valid, o_in_ready, i_data1_vld;
    logic [31:0]  i_data0, i_data1, o_w_data, o_w_data2, o_lit0, o_lit1;
    logic [511:0] i_dict;
    logic         o_wr, o_wr2, o_valid, i_out_ready, o_vld1;
    logic [1:0]   o_hit;
    logic [3:0]   o_loc0, o_loc1, o_mask0, o_mask1;

    int n_assert = 0;
    int n_fail   = 0;

    dict_match_search dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_data0(i_data0), .i_data1(i_data1), .i_data1_vld(i_data1_vld), .i_dict(i_dict),
        .o_wr(o_wr), .o_wr2(o_wr2), .o_w_data(o_w_data), .o_w_data2(o_w_data2),
        .o_valid(o_valid), .i_out_ready(i_out_ready), .o_vld1(o_vld1), .o_hit(o_hit),
        .o_loc0(o_loc0), .o_loc1(o_loc1), .o_mask0(o_mask0), .o_mask1(o_mask1),
        .o_lit0(o_lit0), .o_lit1(o_lit1)
    );

    always #5 i_clk = ~i_clk;

    // Dictionary FIFO: writes on the strobe edge, snapshot visible one edge later.
    logic [31:0] bank1 [8] = '{default: '0};
    logic [31:0] bank2 [8] = '{default: '0};
    int          fp = 0;
    always @(posedge i_clk) begin
        for (int j = 0; j < 16; j++)
            i_dict[j*32 +: 32] <= (j % 2 == 0) ? bank1[j/2] : bank2[j/2];
        if (!i_reset) fp <= 0;
        else if (o_wr) begin
            bank1[fp] <= o_w_data;
            if (o_wr2) bank2[fp] <= o_w_data2;
            fp <= (fp + 1) % 8;
        end
    end

    // Reference: what the dictionary holds from the block's point of view.
    logic [31:0] ref_dict [16];
    bit          ref_vld  [16];
    int          rp = 0;

    typedef struct { logic hit; logic [3:0] loc; logic [3:0] mask; } exp_t;

    function automatic exp_t ref_best(input logic [31:0] w);
        exp_t r;
        int   best;
        logic [3:0] m;
        r    = '{1'b0, 4'd0, 4'd0};
        best = 1;
        for (int j = 0; j < 16; j++) begin
            if (ref_vld[j]) begin
                for (int k = 0; k < 4; k++) m[k] = (ref_dict[j][8*k +: 8] == w[8*k +: 8]);
                if ($countones(m) > best) begin
                    best = $countones(m);
                    r    = '{1'b1, 4'(j), m};
                end
            end
        end
        return r;
    endfunction

    function automatic void ref_insert(input logic [31:0] w0, input logic [31:0] w1, input logic v1);
        ref_dict[2*rp] = w0;
        ref_vld[2*rp]  = 1'b1;
        if (v1) begin
            ref_dict[2*rp+1] = w1;
            ref_vld[2*rp+1]  = 1'b1;
        end
        rp = (rp + 1) % 8;
    endfunction

    function automatic void ref_clear();
        for (int j = 0; j < 16; j++) ref_vld[j] = 1'b0;
        rp = 0;
    endfunction

    function automatic logic [31:0] rword();
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'($urandom_range(0, 3)) * 8'h11;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (o_in_ready !== 1'b1 && t < 20) begin
            @(negedge i_clk);
            t++;
        end
        chk("in_ready_before_fire", o_in_ready, 1);
    endtask

    task automatic send(input logic [31:0] w0, input logic [31:0] w1, input logic v1, input int hold);
        exp_t e0, e1;
        e0 = ref_best(w0);
        e1 = ref_best(w1);
        wait_ready();
        i_valid = 1'b1; i_data0 = w0; i_data1 = w1; i_data1_vld = v1;
        i_out_ready = (hold == 0);
        @(negedge i_clk);
        i_valid = 1'b0; i_data0 = $urandom; i_data1 = $urandom; i_data1_vld = 1'($urandom_range(0, 1));
        chk("wr", o_wr, 1);
        chk("wr2", o_wr2, v1);
        chk("w_data", o_w_data, w0);
        chk("w_data2", o_w_data2, w1);
        chk("busy_wait1", o_in_ready, 0);
        ref_insert(w0, w1, v1);
        @(negedge i_clk);
        chk("busy_wait2", o_in_ready, 0);
        chk("wr_pulse", o_wr, 0);
        for (int c = 0; c <= hold; c++) begin
            if (c > 0) begin
                @(negedge i_clk);
                chk("hold_in_ready", o_in_ready, 0);
                chk("hold_wr", o_wr, 0);
            end
            chk("valid", o_valid, 1);
            chk("vld1", o_vld1, v1);
            chk("hit", o_hit, {e1.hit & v1, e0.hit});
            chk("loc0", o_loc0, e0.loc);
            chk("mask0", o_mask0, e0.mask);
            chk("lit0", o_lit0, w0);
            chk("lit1", o_lit1, w1);
            if (v1) begin
                chk("loc1", o_loc1, e1.loc);
                chk("mask1", o_mask1, e1.mask);
            end
        end
        i_out_ready = 1'b1;
        @(negedge i_clk);
        chk("drained", o_valid, 0);
        chk("idle_ready", o_in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0; i_valid = 1'b0; i_data0 = '0; i_data1 = '0;
        i_data1_vld = 1'b0; i_out_ready = 1'b1;
        ref_clear();
        repeat (3) @(negedge i_clk);
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_wr", o_wr, 0);
        chk("rst_hit", o_hit, 0);
        chk("rst_lit0", o_lit0, 0);
        i_reset = 1'b1;
        #1 chk("release_in_ready", o_in_ready, 1);

        send(32'h11223344, 32'hAABBCCDD, 1'b1, 0);
        send(32'h11223344, 32'h1122FFFF, 1'b1, 0);
        send(32'h55AA55AA, 32'h00000000, 1'b0, 0);   // single word leaves entry 5 invalid
        send(32'h00000000, 32'h0000BEEF, 1'b1, 5);   // downstream stall
        for (int i = 0; i < 6; i++) send(rword(), rword(), 1'($urandom_range(0, 1)), 0);

        // Reset while the pair is in WAIT1: pair dropped, dictionary view cleared.
        wait_ready();
        i_valid = 1'b1; i_data0 = 32'h11223344; i_data1 = 32'h11223344; i_data1_vld = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_in_ready", o_in_ready, 0);
        chk("midrst_wr", o_wr, 0);
        chk("midrst_hit", o_hit, 0);
        ref_clear();
        i_reset = 1'b1;
        #1 chk("midrst_release_ready", o_in_ready, 1);
        @(negedge i_clk);
        send(32'h11223344, 32'h11223344, 1'b1, 0);   // no hit, not even word1 vs word0
        chk("post_rst_nohit", o_hit, 0);

        // Tie: entries 2 and 5 both match three bytes of the query.
        send(32'h55667788, 32'h99999999, 1'b1, 0);
        send(32'h12345678, 32'h55667700, 1'b1, 0);
        send(32'h556677AA, 32'hABABABAB, 1'b1, 0);
        chk("tie_loc", o_loc0, 4'd2);
        chk("tie_mask", o_mask0, 4'b1110);

        for (int i = 0; i < 30; i++)
            send(rword(), rword(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
